// File: rtl/sipo_deser_if.sv
// rtl/sipo_deser_if.sv - serial input, parallel output handshake and status bundle for sipo_deser
interface sipo_deser_if #(
  parameter int WIDTH = 4
);
  logic             serial_i;
  logic             serial_valid_i;
  logic             sof_i;
  logic [WIDTH-1:0] parallel_o;
  logic             valid_o;
  logic             ready_i;
  logic             busy_o;
  logic             overrun_o;
  logic             overrun_clr_i;

  // Producer/consumer side: drives the serial stream and consumes words
  modport master (
    output serial_i, serial_valid_i, sof_i, ready_i, overrun_clr_i,
    input  parallel_o, valid_o, busy_o, overrun_o
  );

  // Deserializer side
  modport slave (
    input  serial_i, serial_valid_i, sof_i, ready_i, overrun_clr_i,
    output parallel_o, valid_o, busy_o, overrun_o
  );
endinterface

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - LSB-first serial-in parallel-out deserializer with valid/ready output and sticky overrun
module sipo_deser #(
  parameter int WIDTH = 4
) (
  input logic         clk,
  input logic         reset,
  sipo_deser_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_ff;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] parallel_q;
  logic             valid_q;
  logic             overrun_q;

  logic [WIDTH-1:0] shift_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] par_nxt;
  logic             valid_nxt;
  logic             ovr_nxt;
  logic [CW-1:0]    eff_cnt;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             transfer;

  // Next-state: shift/count on accepted bits, load or drop completed words, track overrun
  always_comb begin
    eff_cnt   = bus.sof_i ? '0 : bit_cnt;
    word      = {bus.serial_i, shift_ff[WIDTH-1:1]};
    complete  = bus.serial_valid_i && (eff_cnt == LAST);
    transfer  = valid_q && bus.ready_i;
    shift_nxt = shift_ff;
    cnt_nxt   = bit_cnt;
    par_nxt   = parallel_q;
    valid_nxt = valid_q;
    ovr_nxt   = overrun_q;

    if (bus.serial_valid_i) begin
      shift_nxt = word;
      cnt_nxt   = complete ? '0 : eff_cnt + CW'(1);
    end

    if (transfer) begin
      valid_nxt = 1'b0;
    end

    // A completed word only lands if the output slot is free or being emptied now
    if (complete) begin
      if (!valid_q || bus.ready_i) begin
        par_nxt   = word;
        valid_nxt = 1'b1;
      end
    end

    // Clear first so that a simultaneous drop still leaves the flag set
    if (bus.overrun_clr_i) begin
      ovr_nxt = 1'b0;
    end
    if (complete && valid_q && !bus.ready_i) begin
      ovr_nxt = 1'b1;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_ff   <= '0;
      bit_cnt    <= '0;
      parallel_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      shift_ff   <= shift_nxt;
      bit_cnt    <= cnt_nxt;
      parallel_q <= par_nxt;
      valid_q    <= valid_nxt;
      overrun_q  <= ovr_nxt;
    end
  end

  assign bus.parallel_o = parallel_q;
  assign bus.valid_o    = valid_q;
  assign bus.busy_o     = (bit_cnt != '0);
  assign bus.overrun_o  = overrun_q;
endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - scoreboard bench for sipo_deser
module tb_sipo_deser;
  localparam int WIDTH = 4;

  logic clk;
  logic reset;

  sipo_deser_if #(.WIDTH(WIDTH)) bus ();

  sipo_deser #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  logic [WIDTH-1:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every word the consumer takes must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset && bus.valid_o && bus.ready_i) begin
      n_checks++;
      n_xfer++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none", bus.parallel_o);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (bus.parallel_o !== e) begin
          n_fail++;
          $display("FAIL word: got %0h expected %0h at %0t", bus.parallel_o, e, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_cycle(input logic b, input logic s);
    bus.serial_i       = b;
    bus.serial_valid_i = 1'b1;
    bus.sof_i          = s;
    tick();
    bus.serial_valid_i = 1'b0;
    bus.sof_i          = 1'b0;
    bus.serial_i       = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic first_sof);
    for (int i = 0; i < WIDTH; i++) bit_cycle(w[i], first_sof && (i == 0));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] w;
    reset              = 1'b0;
    bus.serial_i       = 1'b0;
    bus.serial_valid_i = 1'b0;
    bus.sof_i          = 1'b0;
    bus.ready_i        = 1'b0;
    bus.overrun_clr_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    check("rst_parallel", 32'(bus.parallel_o), 32'h0);
    check("rst_valid",    32'(bus.valid_o),    32'h0);
    check("rst_busy",     32'(bus.busy_o),     32'h0);
    check("rst_overrun",  32'(bus.overrun_o),  32'h0);

    // 1: bits 1,0,1,1 with sof -> 4'hD, busy for 3 cycles
    exp_q.push_back(4'hD);
    bit_cycle(1'b1, 1'b1); check("t1_busy1", 32'(bus.busy_o), 32'h1);
    bit_cycle(1'b0, 1'b0); check("t1_busy2", 32'(bus.busy_o), 32'h1);
    bit_cycle(1'b1, 1'b0); check("t1_busy3", 32'(bus.busy_o), 32'h1);
    check("t1_valid_early", 32'(bus.valid_o), 32'h0);
    bit_cycle(1'b1, 1'b0);
    check("t1_valid",    32'(bus.valid_o),    32'h1);
    check("t1_parallel", 32'(bus.parallel_o), 32'hD);
    check("t1_busy_end", 32'(bus.busy_o),     32'h0);

    // 2: stalled consumer drops 4'h6 and flags overrun
    send_word(4'h6, 1'b0);
    check("t2_parallel", 32'(bus.parallel_o), 32'hD);
    check("t2_valid",    32'(bus.valid_o),    32'h1);
    check("t2_overrun",  32'(bus.overrun_o),  32'h1);
    bus.overrun_clr_i = 1'b1;
    tick();
    bus.overrun_clr_i = 1'b0;
    check("t2_overrun_clr", 32'(bus.overrun_o), 32'h0);
    bus.ready_i = 1'b1;
    tick();
    check("t2_drained", 32'(bus.valid_o), 32'h0);
    check("t2_hold_par", 32'(bus.parallel_o), 32'hD);

    // 3: continuous stream with ready held high
    w = 4'hA; exp_q.push_back(w); send_word(w, 1'b0);
    check("t3_validA", 32'(bus.valid_o), 32'h1);
    w = 4'h5; exp_q.push_back(w); send_word(w, 1'b0);
    check("t3_valid5", 32'(bus.valid_o), 32'h1);
    w = 4'hF; exp_q.push_back(w); send_word(w, 1'b0);
    check("t3_validF", 32'(bus.valid_o), 32'h1);
    tick();
    check("t3_idle", 32'(bus.valid_o), 32'h0);

    // 4: partial word discarded by sof; bits 0,1,1,1 -> 4'hE
    bit_cycle(1'b1, 1'b0);
    bit_cycle(1'b1, 1'b0);
    check("t4_busy_partial", 32'(bus.busy_o), 32'h1);
    exp_q.push_back(4'hE);
    bit_cycle(1'b0, 1'b1);
    bit_cycle(1'b1, 1'b0);
    bit_cycle(1'b1, 1'b0);
    bit_cycle(1'b1, 1'b0);
    check("t4_parallel", 32'(bus.parallel_o), 32'hE);
    check("t4_overrun",  32'(bus.overrun_o),  32'h0);
    tick();

    // 5: 4'h9 with two idle cycles between bits
    exp_q.push_back(4'h9);
    w = 4'h9;
    for (int i = 0; i < WIDTH; i++) begin
      bit_cycle(w[i], 1'b0);
      if (i < WIDTH - 1) begin
        tick();
        tick();
        check("t5_busy_gap", 32'(bus.busy_o), 32'h1);
        check("t5_valid_gap", 32'(bus.valid_o), 32'h0);
      end
    end
    check("t5_parallel", 32'(bus.parallel_o), 32'h9);
    tick();

    // 6: reset mid-word with valid and overrun set, then word without sof
    bus.ready_i = 1'b0;
    send_word(4'h3, 1'b0);
    send_word(4'h7, 1'b0);
    bit_cycle(1'b1, 1'b0);
    bit_cycle(1'b0, 1'b0);
    bit_cycle(1'b1, 1'b0);
    check("t6_pre_valid",   32'(bus.valid_o),   32'h1);
    check("t6_pre_overrun", 32'(bus.overrun_o), 32'h1);
    check("t6_pre_busy",    32'(bus.busy_o),    32'h1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t6_parallel", 32'(bus.parallel_o), 32'h0);
    check("t6_valid",    32'(bus.valid_o),    32'h0);
    check("t6_busy",     32'(bus.busy_o),     32'h0);
    check("t6_overrun",  32'(bus.overrun_o),  32'h0);
    bus.ready_i = 1'b1;
    exp_q.push_back(4'hB);
    send_word(4'hB, 1'b0);
    check("t6_parallel_b", 32'(bus.parallel_o), 32'hB);
    tick();
    check("t6_idle", 32'(bus.valid_o), 32'h0);

    check("sb_empty", 32'(exp_q.size()), 32'h0);
    check("xfer_count", 32'(n_xfer), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
